// File: rtl/freq_pkg.sv
// Shared types and defaults for the recovered-clock frequency lock controller.
package freq_pkg;

  // Nominal clk_sys frequency; also the default 1 s gate length
  localparam int unsigned CLK_HZ_DEF = 12_000_000;
  // Default pulse count / target width
  localparam int unsigned CNT_W_DEF  = 20;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StSettle,
    StSample,
    StCheck
  } freq_state_e;

endpackage

// File: rtl/freq_lock_filter.sv
// Debounce filter: turns per-window in-range results into a locked flag with
// one-cycle lock/unlock event pulses.
module freq_lock_filter #(
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 2
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic check,
  input  logic in_range,
  input  logic abort,
  output logic locked,
  output logic lock_event,
  output logic unlock_event
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW  = $clog2(UNLOCK_COUNT + 1);
  localparam logic [GoodW-1:0] GoodMax = GoodW'(LOCK_COUNT);
  localparam logic [BadW-1:0]  BadMax  = BadW'(UNLOCK_COUNT);

  logic [GoodW-1:0] good_q, good_d;
  logic [BadW-1:0]  bad_q, bad_d;

  // Saturating streak update for the result presented at CHECK
  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (in_range) begin
      good_d = (good_q == GoodMax) ? good_q : good_q + 1'b1;
      bad_d  = '0;
    end else begin
      bad_d  = (bad_q == BadMax) ? bad_q : bad_q + 1'b1;
      good_d = '0;
    end
  end

  // Streak registers, lock flag and change-only event pulses
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      good_q       <= '0;
      bad_q        <= '0;
      locked       <= 1'b0;
      lock_event   <= 1'b0;
      unlock_event <= 1'b0;
    end else begin
      lock_event   <= 1'b0;
      unlock_event <= 1'b0;
      if (abort) begin
        good_q <= '0;
        bad_q  <= '0;
        if (locked) begin
          locked       <= 1'b0;
          unlock_event <= 1'b1;
        end
      end else if (check) begin
        good_q <= good_d;
        bad_q  <= bad_d;
        if (!locked && (good_d == GoodMax)) begin
          locked     <= 1'b1;
          lock_event <= 1'b1;
        end else if (locked && (bad_d == BadMax)) begin
          locked       <= 1'b0;
          unlock_event <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/freq_lock_ctrl.sv
// Frequency measurement sequencer: clears the pulse counter, gates it for
// GATE_CYCLES, waits for the count to settle across the CDC, samples it and
// compares against target_freq +/- tolerance, then debounces into locked.
// Optional macro FREQ_LOCK_HYST_EN doubles the tolerance while locked.
module freq_lock_ctrl
  import freq_pkg::*;
#(
  parameter int unsigned CLK_HZ        = CLK_HZ_DEF,
  parameter int unsigned GATE_CYCLES   = CLK_HZ,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned TOL_W         = 16,
  parameter int unsigned LOCK_COUNT    = 3,
  parameter int unsigned UNLOCK_COUNT  = 2
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] target_freq,
  input  logic [TOL_W-1:0] tolerance,
  output logic             cnt_clear,
  output logic             cnt_gate,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_value,
  output logic             in_range,
  output logic             locked,
  output logic             lock_event,
  output logic             unlock_event
);

  localparam int unsigned TimerMax = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam int unsigned CmpW     = (CNT_W > TOL_W) ? CNT_W + 1 : TOL_W + 1;

  freq_state_e      state_q;
  logic [TimerW-1:0] timer_q;
  logic [CNT_W-1:0] target_q;
  logic [TOL_W-1:0] tol_q;
  logic [CNT_W-1:0] meas_q;

  logic             abort;
  logic             check;
  logic [CNT_W:0]   diff;
  logic [TOL_W:0]   tol_eff;
  logic             in_range_c;

  // Dropping enable before the result is sampled abandons the window
  assign abort = !enable && (state_q inside {StClear, StGate, StSettle, StSample});
  assign check = (state_q == StCheck);

  // Absolute difference in CNT_W+1 bits and effective tolerance for this window
  always_comb begin
    diff = (meas_q >= target_q) ? {1'b0, meas_q - target_q} : {1'b0, target_q - meas_q};
`ifdef FREQ_LOCK_HYST_EN
    tol_eff = locked ? {tol_q, 1'b0} : {1'b0, tol_q};
`else
    tol_eff = {1'b0, tol_q};
`endif
    in_range_c = (CmpW'(diff) <= CmpW'(tol_eff));
  end

  // Window sequencer with registered counter controls and result outputs
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      target_q   <= '0;
      tol_q      <= '0;
      meas_q     <= '0;
      cnt_clear  <= 1'b0;
      cnt_gate   <= 1'b0;
      meas_valid <= 1'b0;
      meas_value <= '0;
      in_range   <= 1'b0;
    end else begin
      cnt_clear  <= 1'b0;
      meas_valid <= 1'b0;
      if (abort) begin
        state_q  <= StIdle;
        cnt_gate <= 1'b0;
        timer_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (enable) begin
              state_q   <= StClear;
              cnt_clear <= 1'b1;
            end
          end
          StClear: begin
            target_q <= target_freq;
            tol_q    <= tolerance;
            timer_q  <= '0;
            cnt_gate <= 1'b1;
            state_q  <= StGate;
          end
          StGate: begin
            if (timer_q == TimerW'(GATE_CYCLES - 1)) begin
              timer_q  <= '0;
              cnt_gate <= 1'b0;
              state_q  <= StSettle;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          StSettle: begin
            if (timer_q == TimerW'(SETTLE_CYCLES - 1)) begin
              timer_q <= '0;
              state_q <= StSample;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          StSample: begin
            meas_q  <= cnt_value;
            state_q <= StCheck;
          end
          StCheck: begin
            meas_valid <= 1'b1;
            meas_value <= meas_q;
            in_range   <= in_range_c;
            if (enable) begin
              state_q   <= StClear;
              cnt_clear <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  freq_lock_filter #(
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) u_filter (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .check       (check),
    .in_range    (in_range_c),
    .abort       (abort),
    .locked      (locked),
    .lock_event  (lock_event),
    .unlock_event(unlock_event)
  );

endmodule

// File: tb/tb_freq_lock_ctrl.sv
// Bench for freq_lock_ctrl with a short gate; expected window results are
// queued when a window's stimulus is driven and checked at meas_valid.
module tb_freq_lock_ctrl;

  localparam int unsigned CntW = 20;
  localparam int unsigned TolW = 16;

  logic            clk_sys = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [CntW-1:0] target_freq = '0;
  logic [TolW-1:0] tolerance = '0;
  logic [CntW-1:0] cnt_value = '0;
  logic            cnt_clear, cnt_gate, meas_valid, in_range, locked;
  logic            lock_event, unlock_event;
  logic [CntW-1:0] meas_value;

  typedef struct packed {
    logic [CntW-1:0] value;
    logic            in_r;
    logic            lk;
    logic            le;
    logic            ue;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk_sys = ~clk_sys;

  freq_lock_ctrl #(
    .GATE_CYCLES  (100),
    .SETTLE_CYCLES(4),
    .CNT_W        (CntW),
    .TOL_W        (TolW),
    .LOCK_COUNT   (3),
    .UNLOCK_COUNT (2)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .enable      (enable),
    .target_freq (target_freq),
    .tolerance   (tolerance),
    .cnt_clear   (cnt_clear),
    .cnt_gate    (cnt_gate),
    .cnt_value   (cnt_value),
    .meas_valid  (meas_valid),
    .meas_value  (meas_value),
    .in_range    (in_range),
    .locked      (locked),
    .lock_event  (lock_event),
    .unlock_event(unlock_event)
  );

  // Wait for the next meas_valid and compare it with the oldest queued expectation
  task automatic collect(input string name, output int cycles);
    exp_t e;
    cycles = 0;
    do begin
      @(negedge clk_sys);
      cycles++;
    end while (!meas_valid && cycles < 400);
    e = exp_q.pop_front();
    n_checks++;
    if (!meas_valid) begin
      $display("FAIL %s timeout: meas_valid=%0b after %0d cycles, required 1", name, meas_valid,
               cycles);
    end else begin
      n_pass++;
      n_checks++;
      if (meas_value !== e.value)
        $display("FAIL %s meas_value: got %0d required %0d", name, meas_value, e.value);
      else n_pass++;
      n_checks++;
      if (in_range !== e.in_r)
        $display("FAIL %s in_range: got %0b required %0b", name, in_range, e.in_r);
      else n_pass++;
      n_checks++;
      if (locked !== e.lk) $display("FAIL %s locked: got %0b required %0b", name, locked, e.lk);
      else n_pass++;
      n_checks++;
      if (lock_event !== e.le)
        $display("FAIL %s lock_event: got %0b required %0b", name, lock_event, e.le);
      else n_pass++;
      n_checks++;
      if (unlock_event !== e.ue)
        $display("FAIL %s unlock_event: got %0b required %0b", name, unlock_event, e.ue);
      else n_pass++;
    end
  endtask

  // Drive one window's inputs (latched at CLEAR) and check its result
  task automatic run_window(input string name, input logic [CntW-1:0] tgt,
                            input logic [TolW-1:0] tl, input logic [CntW-1:0] cnt,
                            input logic ei, input logic el, input logic ele, input logic eue);
    int cyc;
    exp_q.push_back('{value: cnt, in_r: ei, lk: el, le: ele, ue: eue});
    target_freq = tgt;
    tolerance   = tl;
    cnt_value   = cnt;
    collect(name, cyc);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if ({cnt_clear, cnt_gate, meas_valid, in_range, locked, lock_event, unlock_event} !== 7'b0 ||
        meas_value !== '0)
      $display("FAIL reset_outputs: got clr=%0b gate=%0b mv=%0b ir=%0b lk=%0b le=%0b ue=%0b val=%0d required all 0",
               cnt_clear, cnt_gate, meas_valid, in_range, locked, lock_event, unlock_event,
               meas_value);
    else n_pass++;
  endtask

  task automatic test_timing;
    int n;
    int gate_n;
    target_freq = 20'd1000;
    tolerance   = 16'd5;
    cnt_value   = 20'd0;
    rst_n       = 1'b1;
    n = 0;
    while (!cnt_clear && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    n_checks++;
    if (n !== 1) $display("FAIL timing_clear_start: cycles %0d required 1", n);
    else n_pass++;
    @(negedge clk_sys);
    n_checks++;
    if (cnt_clear !== 1'b0 || cnt_gate !== 1'b1)
      $display("FAIL timing_clear_width: clr=%0b gate=%0b required clr=0 gate=1", cnt_clear,
               cnt_gate);
    else n_pass++;
    gate_n = 0;
    while (cnt_gate && gate_n < 300) begin
      gate_n++;
      @(negedge clk_sys);
    end
    n_checks++;
    if (gate_n !== 100) $display("FAIL timing_gate_len: got %0d required 100", gate_n);
    else n_pass++;
    n = 0;
    while (!meas_valid && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!meas_valid && n < 300);
    n_checks++;
    if (n !== 107) $display("FAIL timing_period: got %0d required 107", n);
    else n_pass++;
    n_checks++;
    if (in_range !== 1'b0 || meas_value !== 20'd0)
      $display("FAIL timing_result: in_range=%0b value=%0d required 0/0", in_range, meas_value);
    else n_pass++;
  endtask

  task automatic test_lock;
    run_window("lock_w1", 20'd1000, 16'd5, 20'd1003, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("lock_w2", 20'd1000, 16'd5, 20'd1003, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("lock_w3", 20'd1000, 16'd5, 20'd1003, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk_sys);
    n_checks++;
    if (lock_event !== 1'b0 || meas_valid !== 1'b0)
      $display("FAIL lock_pulse_width: lock_event=%0b meas_valid=%0b required 0/0", lock_event,
               meas_valid);
    else n_pass++;
  endtask

  task automatic test_unlock;
`ifdef FREQ_LOCK_HYST_EN
    run_window("unlock_hyst_1010", 20'd1000, 16'd5, 20'd1010, 1'b1, 1'b1, 1'b0, 1'b0);
    run_window("unlock_hyst_w1", 20'd1000, 16'd5, 20'd1011, 1'b0, 1'b1, 1'b0, 1'b0);
    run_window("unlock_hyst_w2", 20'd1000, 16'd5, 20'd1011, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    run_window("unlock_w1", 20'd1000, 16'd5, 20'd1010, 1'b0, 1'b1, 1'b0, 1'b0);
    run_window("unlock_w2", 20'd1000, 16'd5, 20'd1010, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_streak;
    run_window("streak_in1", 20'd1000, 16'd5, 20'd1003, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("streak_in2", 20'd1000, 16'd5, 20'd1003, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("streak_out", 20'd1000, 16'd5, 20'd1010, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window("streak_in3", 20'd1000, 16'd5, 20'd995, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("streak_in4", 20'd1000, 16'd5, 20'd1005, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("streak_in5", 20'd1000, 16'd5, 20'd1003, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_shadow;
    int cyc;
    exp_q.push_back('{value: 20'd1003, in_r: 1'b1, lk: 1'b1, le: 1'b0, ue: 1'b0});
    target_freq = 20'd1000;
    cnt_value   = 20'd1003;
    repeat (20) @(negedge clk_sys);
    target_freq = 20'd2000;
    collect("shadow_old_target", cyc);
    run_window("shadow_new_target", 20'd2000, 16'd5, 20'd1003, 1'b0, 1'b1, 1'b0, 1'b0);
    run_window("shadow_restore", 20'd1000, 16'd5, 20'd1003, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_abort;
    int n;
    int mv_n;
    int ue_n;
    int clr_n;
    int cyc;
    n = 0;
    while (!cnt_gate && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (49) @(negedge clk_sys);
    enable = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (cnt_gate !== 1'b0 || locked !== 1'b0 || unlock_event !== 1'b1 || meas_valid !== 1'b0)
      $display("FAIL abort_edge: gate=%0b locked=%0b ue=%0b mv=%0b required 0/0/1/0", cnt_gate,
               locked, unlock_event, meas_valid);
    else n_pass++;
    mv_n = 0;
    ue_n = 0;
    clr_n = 0;
    repeat (150) begin
      @(negedge clk_sys);
      mv_n += int'(meas_valid);
      ue_n += int'(unlock_event);
      clr_n += int'(cnt_clear | cnt_gate);
    end
    n_checks++;
    if (mv_n !== 0 || ue_n !== 0 || clr_n !== 0)
      $display("FAIL abort_idle: meas_valid=%0d unlock_event=%0d clear/gate=%0d required 0/0/0",
               mv_n, ue_n, clr_n);
    else n_pass++;
    exp_q.push_back('{value: 20'd1003, in_r: 1'b1, lk: 1'b0, le: 1'b0, ue: 1'b0});
    target_freq = 20'd1000;
    cnt_value   = 20'd1003;
    enable      = 1'b1;
    collect("abort_restart", cyc);
    n_checks++;
    if (cyc !== 108) $display("FAIL abort_restart_latency: got %0d required 108", cyc);
    else n_pass++;
  endtask

  task automatic test_reset_locked;
    run_window("relock_w2", 20'd1000, 16'd5, 20'd1003, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("relock_w3", 20'd1000, 16'd5, 20'd1003, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (30) @(negedge clk_sys);
    rst_n = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (locked !== 1'b0 || unlock_event !== 1'b0 || cnt_gate !== 1'b0 || in_range !== 1'b0 ||
        meas_value !== '0)
      $display("FAIL reset_while_locked: lk=%0b ue=%0b gate=%0b ir=%0b val=%0d required all 0",
               locked, unlock_event, cnt_gate, in_range, meas_value);
    else n_pass++;
    @(negedge clk_sys);
    n_checks++;
    if (unlock_event !== 1'b0 || lock_event !== 1'b0)
      $display("FAIL reset_no_event: ue=%0b le=%0b required 0/0", unlock_event, lock_event);
    else n_pass++;
  endtask

  task automatic test_boundaries;
    rst_n = 1'b1;
    run_window("bnd_zero", 20'd0, 16'd0, 20'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("bnd_ones_eq", 20'hFFFFF, 16'd0, 20'hFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("bnd_ones_far", 20'd0, 16'hFFFF, 20'hFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window("bnd_tol_edge", 20'd1000, 16'd5, 20'd995, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("bnd_tol_over", 20'd1000, 16'd5, 20'd1006, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window("bnd_ones_below", 20'hFFFFF, 16'd1, 20'hFFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk_sys);
    test_reset();
    test_timing();
    test_lock();
    test_unlock();
    test_streak();
    test_shadow();
    test_abort();
    test_reset_locked();
    test_boundaries();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
